// File: rtl/cpu_pkg.sv
// -----------------------------------------------------------------------------
// cpu_pkg
// Shared definitions for the accumulator CPU core: opcode encoding, control
// FSM state encoding, flag bit positions and a width helper.
// No ports (package).
// -----------------------------------------------------------------------------
package cpu_pkg;

   localparam int OPC_W   = 4;
   localparam int FLAGS_W = 3;

   // Flag vector layout is {C, N, Z}
   localparam int FLAG_Z = 0;
   localparam int FLAG_N = 1;
   localparam int FLAG_C = 2;

   typedef enum logic [OPC_W-1:0] {
      OP_NOP = 4'd0,
      OP_LDA = 4'd1,
      OP_ADD = 4'd2,
      OP_SUB = 4'd3,
      OP_AND = 4'd4,
      OP_OR  = 4'd5,
      OP_XOR = 4'd6,
      OP_STA = 4'd7,
      OP_OUT = 4'd8,
      OP_JMP = 4'd9,
      OP_JZ  = 4'd10,
      OP_JN  = 4'd11,
      OP_JC  = 4'd12,
      OP_R13 = 4'd13,
      OP_R14 = 4'd14,
      OP_HLT = 4'd15
   } opcode_e;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_FETCH  = 3'd1,
      ST_DECODE = 3'd2,
      ST_EXEC   = 3'd3,
      ST_HALT   = 3'd4
   } state_e;

   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      return m;
   endfunction

endpackage

// File: rtl/alu_param.sv
// -----------------------------------------------------------------------------
// alu_param
// Combinational ALU for the accumulator CPU. Works at DATA_W+1 bits so the
// top bit carries the ADD carry / SUB borrow.
//   a      in  DATA_W  accumulator operand
//   b      in  DATA_W  memory operand
//   op     in  4       opcode (LDA passes b through)
//   result out DATA_W  low DATA_W bits of the operation
//   c      out 1       ADD: carry out; SUB: 1 when no borrow (a >= b)
//   n      out 1       result MSB
//   z      out 1       result is zero
// -----------------------------------------------------------------------------
module alu_param
   import cpu_pkg::*;
#(
   parameter int DATA_W = 8
) (
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   input  opcode_e           op,
   output logic [DATA_W-1:0] result,
   output logic              c,
   output logic              n,
   output logic              z
);

   logic [DATA_W:0] wide_s;

   // Operation select at extended width
   always_comb begin
      wide_s = '0;
      case (op)
         OP_LDA:  wide_s = {1'b0, b};
         OP_ADD:  wide_s = {1'b0, a} + {1'b0, b};
         OP_SUB:  wide_s = {1'b0, a} - {1'b0, b};
         OP_AND:  wide_s = {1'b0, a & b};
         OP_OR:   wide_s = {1'b0, a | b};
         OP_XOR:  wide_s = {1'b0, a ^ b};
         default: wide_s = {1'b0, a};
      endcase
   end

   assign result = wide_s[DATA_W-1:0];
   // For SUB the extended bit is a borrow; the flag reports its inverse
   assign c      = (op == OP_SUB) ? ~wide_s[DATA_W] : wide_s[DATA_W];
   assign n      = wide_s[DATA_W-1];
   assign z      = (wide_s[DATA_W-1:0] == '0);

endmodule

// File: rtl/accum_cpu_core.sv
// -----------------------------------------------------------------------------
// accum_cpu_core
// Parametrised accumulator CPU. Instruction and data memories are filled
// through one load port while idle/halted, then a start pulse runs the
// program with a fixed 3-cycle FETCH/DECODE/EXEC sequence per instruction.
//   clk            in  1        rising-edge clock
//   reset          in  1        synchronous, active-high
//   cpu_input      in  IN_W     load word (instr: [INSTR_W-1:0], data: [DATA_W-1:0])
//   load_address   in  IMEM_AW  load target (data uses low DMEM_AW bits)
//   load           in  1        write strobe, honoured only in IDLE/HALT
//   is_instruction in  1        1 = instruction memory, 0 = data memory
//   start          in  1        run from pc 0 (IDLE/HALT only)
//   output_value   out DATA_W   value of the last OUT
//   out_index      out OUT_AW   index tag of the last OUT
//   out_valid      out 1        one-cycle pulse per OUT
//   busy           out 1        FETCH, DECODE or EXEC
//   halted         out 1        HLT executed
//   flags          out 3        {C, N, Z}
//   pc             out IMEM_AW  program counter
// -----------------------------------------------------------------------------
module accum_cpu_core
   import cpu_pkg::*;
#(
   parameter  int DATA_W  = 8,
   parameter  int IMEM_AW = 5,
   parameter  int DMEM_AW = 4,
   parameter  int OUT_AW  = 5,
   localparam int OPR_W   = max3(IMEM_AW, DMEM_AW, OUT_AW),
   localparam int INSTR_W = OPC_W + OPR_W,
   localparam int IN_W    = max3(DATA_W, INSTR_W, 1)
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [IN_W-1:0]    cpu_input,
   input  logic [IMEM_AW-1:0] load_address,
   input  logic               load,
   input  logic               is_instruction,
   input  logic               start,
   output logic [DATA_W-1:0]  output_value,
   output logic [OUT_AW-1:0]  out_index,
   output logic               out_valid,
   output logic               busy,
   output logic               halted,
   output logic [FLAGS_W-1:0] flags,
   output logic [IMEM_AW-1:0] pc
);

   logic [INSTR_W-1:0] imem_r [2**IMEM_AW];
   logic [DATA_W-1:0]  dmem_r [2**DMEM_AW];

   state_e             state_r, state_next_s;
   logic [IMEM_AW-1:0] pc_r, pc_next_s, pc_inc_s;
   logic [DATA_W-1:0]  acc_r, opnd_r;
   logic [INSTR_W-1:0] ir_r;
   logic [FLAGS_W-1:0] flags_r;
   logic [DATA_W-1:0]  output_value_r;
   logic [OUT_AW-1:0]  out_index_r;
   logic               out_valid_r, busy_r, halted_r;

   opcode_e            opc_s;
   logic [OPR_W-1:0]   operand_s;
   logic [DMEM_AW-1:0] data_addr_s;
   logic [IMEM_AW-1:0] jump_tgt_s;
   logic               idle_s;
   logic               imem_we_s, dmem_we_s;
   logic [DMEM_AW-1:0] dmem_waddr_s;
   logic [DATA_W-1:0]  dmem_wdata_s;

   logic [DATA_W-1:0]  alu_res_s;
   logic               alu_c_s, alu_n_s, alu_z_s;

   assign opc_s       = opcode_e'(ir_r[INSTR_W-1 -: OPC_W]);
   assign operand_s   = ir_r[OPR_W-1:0];
   assign data_addr_s = operand_s[DMEM_AW-1:0];
   assign jump_tgt_s  = operand_s[IMEM_AW-1:0];
   assign pc_inc_s    = pc_r + IMEM_AW'(1);
   assign idle_s      = (state_r == ST_IDLE) || (state_r == ST_HALT);

   alu_param #(.DATA_W(DATA_W)) u_alu (
      .a      (acc_r),
      .b      (opnd_r),
      .op     (opc_s),
      .result (alu_res_s),
      .c      (alu_c_s),
      .n      (alu_n_s),
      .z      (alu_z_s)
   );

   // Next-state logic of the control FSM
   always_comb begin
      state_next_s = state_r;
      case (state_r)
         ST_IDLE, ST_HALT: begin
            if (start) state_next_s = ST_FETCH;
            else       state_next_s = state_r;
         end
         ST_FETCH:  state_next_s = ST_DECODE;
         ST_DECODE: state_next_s = ST_EXEC;
         ST_EXEC: begin
            if (opc_s == OP_HLT) state_next_s = ST_HALT;
            else                 state_next_s = ST_FETCH;
         end
         default:   state_next_s = ST_IDLE;
      endcase
   end

   // Control FSM state register
   always_ff @(posedge clk) begin
      if (reset) state_r <= ST_IDLE;
      else       state_r <= state_next_s;
   end

   // Program-counter update for the instruction in EXEC; branches test
   // the flags as they stood before this instruction
   always_comb begin
      pc_next_s = pc_inc_s;
      case (opc_s)
         OP_JMP: pc_next_s = jump_tgt_s;
         OP_JZ: begin
            if (flags_r[FLAG_Z]) pc_next_s = jump_tgt_s;
            else                 pc_next_s = pc_inc_s;
         end
         OP_JN: begin
            if (flags_r[FLAG_N]) pc_next_s = jump_tgt_s;
            else                 pc_next_s = pc_inc_s;
         end
         OP_JC: begin
            if (flags_r[FLAG_C]) pc_next_s = jump_tgt_s;
            else                 pc_next_s = pc_inc_s;
         end
         OP_HLT:  pc_next_s = pc_r;
         default: pc_next_s = pc_inc_s;
      endcase
   end

   // Memory write arbitration; reset blocks every write so an abort
   // never leaves a partial STA behind
   always_comb begin
      imem_we_s    = 1'b0;
      dmem_we_s    = 1'b0;
      dmem_waddr_s = '0;
      dmem_wdata_s = '0;
      if (reset) begin
         imem_we_s = 1'b0;
         dmem_we_s = 1'b0;
      end else if (load && idle_s) begin
         imem_we_s    = is_instruction;
         dmem_we_s    = ~is_instruction;
         dmem_waddr_s = load_address[DMEM_AW-1:0];
         dmem_wdata_s = cpu_input[DATA_W-1:0];
      end else if ((state_r == ST_EXEC) && (opc_s == OP_STA)) begin
         dmem_we_s    = 1'b1;
         dmem_waddr_s = data_addr_s;
         dmem_wdata_s = acc_r;
      end else begin
         imem_we_s = 1'b0;
         dmem_we_s = 1'b0;
      end
   end

   // Memory arrays; contents survive reset
   always_ff @(posedge clk) begin
      if (imem_we_s) imem_r[load_address] <= cpu_input[INSTR_W-1:0];
      if (dmem_we_s) dmem_r[dmem_waddr_s] <= dmem_wdata_s;
   end

   // Datapath and output registers
   always_ff @(posedge clk) begin
      if (reset) begin
         pc_r           <= '0;
         acc_r          <= '0;
         opnd_r         <= '0;
         ir_r           <= '0;
         flags_r        <= '0;
         output_value_r <= '0;
         out_index_r    <= '0;
         out_valid_r    <= 1'b0;
         busy_r         <= 1'b0;
         halted_r       <= 1'b0;
      end else begin
         out_valid_r <= 1'b0;
         busy_r      <= (state_next_s == ST_FETCH) || (state_next_s == ST_DECODE) ||
                        (state_next_s == ST_EXEC);
         case (state_r)
            ST_IDLE, ST_HALT: begin
               if (start) begin
                  pc_r     <= '0;
                  acc_r    <= '0;
                  flags_r  <= '0;
                  halted_r <= 1'b0;
               end
            end
            ST_FETCH:  ir_r   <= imem_r[pc_r];
            ST_DECODE: opnd_r <= dmem_r[data_addr_s];
            ST_EXEC: begin
               case (opc_s)
                  OP_LDA, OP_AND, OP_OR, OP_XOR: begin
                     acc_r           <= alu_res_s;
                     flags_r[FLAG_Z] <= alu_z_s;
                     flags_r[FLAG_N] <= alu_n_s;
                  end
                  OP_ADD, OP_SUB: begin
                     acc_r           <= alu_res_s;
                     flags_r[FLAG_Z] <= alu_z_s;
                     flags_r[FLAG_N] <= alu_n_s;
                     flags_r[FLAG_C] <= alu_c_s;
                  end
                  OP_OUT: begin
                     output_value_r <= acc_r;
                     out_index_r    <= operand_s[OUT_AW-1:0];
                     out_valid_r    <= 1'b1;
                  end
                  OP_HLT:  halted_r <= 1'b1;
                  default: ;
               endcase
               pc_r <= pc_next_s;
            end
            default: ;
         endcase
      end
   end

   assign output_value = output_value_r;
   assign out_index    = out_index_r;
   assign out_valid    = out_valid_r;
   assign busy         = busy_r;
   assign halted       = halted_r;
   assign flags        = flags_r;
   assign pc           = pc_r;

endmodule

// File: doc/accum_cpu_core.md
Name: accum_cpu_core

Overview:
- Parametrised successor to the 8-bit accumulator CPU. Same load-then-run model: instruction and data memories are filled through one unified load port, then the program executes.
- Adds a start/halt control FSM, a 3-phase fetch/decode/execute sequence, conditional branches, ALU flags, a store instruction and a handshaked output stream.
- Sits at top level; drives the output bus consumed by board/testbench logic.

Parameters:
- DATA_W, 8, datapath, accumulator and data-memory word width
- IMEM_AW, 5, instruction-memory address width (depth 2^IMEM_AW)
- DMEM_AW, 4, data-memory address width (depth 2^DMEM_AW); must be <= IMEM_AW
- OUT_AW, 5, output-index width
- Derived localparams:
  - OPC_W = 4
  - OPR_W = max(IMEM_AW, DMEM_AW, OUT_AW)
  - INSTR_W = OPC_W + OPR_W
  - IN_W = max(DATA_W, INSTR_W)

Ports:
- clk  in  1  single clock, rising edge
- reset  in  1  synchronous, active-high
- cpu_input  in  IN_W  load word; instruction uses [INSTR_W-1:0], data uses [DATA_W-1:0]
- load_address  in  IMEM_AW  load target; data loads use low DMEM_AW bits
- load  in  1  write strobe
- is_instruction  in  1  1 = load instruction memory, 0 = load data memory
- start  in  1  begin execution from PC 0
- output_value  out  DATA_W  last value emitted by OUT
- out_index  out  OUT_AW  index tag of last OUT
- out_valid  out  1  one-cycle pulse per OUT
- busy  out  1  FSM is in FETCH, DECODE or EXEC
- halted  out  1  HLT executed
- flags  out  3  {C, N, Z}
- pc  out  IMEM_AW  current program counter

Behaviour:
- Reset (sync): state IDLE; pc, acc, flags, output_value, out_index, out_valid, halted all 0. Memory contents are not cleared.
- Instruction word: opcode = [INSTR_W-1 -: 4], operand = [OPR_W-1:0].
  - Data address = operand[DMEM_AW-1:0]; jump target = operand[IMEM_AW-1:0]; out index = operand[OUT_AW-1:0].
- Opcodes:
  - 0 NOP
  - 1 LDA: acc = dmem[a]
  - 2 ADD, 3 SUB, 4 AND, 5 OR, 6 XOR: acc = acc op dmem[a]
  - 7 STA: dmem[a] = acc
  - 8 OUT
  - 9 JMP
  - 10 JZ, 11 JN, 12 JC
  - 15 HLT
  - 13, 14: treated as NOP
- FSM states: IDLE, FETCH, DECODE, EXEC, HALT.
  - IDLE/HALT + start: pc = 0, acc = 0, flags = 0, halted = 0, go to FETCH.
  - FETCH: ir <= imem[pc]; go to DECODE.
  - DECODE: opnd <= dmem[a]; go to EXEC.
  - EXEC: commit result, update pc, go to FETCH (HLT: go to HALT, halted = 1, pc holds).
- Timing: every instruction takes exactly 3 cycles. Result is visible on the edge ending EXEC.
- PC update:
  - pc + 1, modulo 2^IMEM_AW (wraps from max to 0).
  - Taken branch: pc = target. JZ/JN/JC test the flags as they stand before EXEC.
- Arithmetic:
  - Computed at DATA_W+1 bits; acc takes the low DATA_W bits.
  - ADD: C = carry out.
  - SUB: acc - opnd; C = 1 when no borrow (acc >= opnd).
  - Z and N (N = acc MSB) update on LDA and all ALU ops. C updates only on ADD/SUB and holds otherwise.
  - STA, OUT, NOP and jumps leave flags unchanged.
- OUT: on the EXEC edge, output_value = acc and out_index = operand. out_valid is high for exactly the following cycle.
- Load port:
  - Honoured only in IDLE or HALT; ignored (no write) while busy.
  - load and start in the same cycle: the write commits, then start is accepted, so the first FETCH sees the new word.
- start while busy is ignored.
- Reset mid-run aborts immediately: all state returns to reset values, no partial STA/OUT.
- STA followed by LDA of the same address returns the stored value (write completes in EXEC, before the next DECODE).

Decomposition:
- cpu_pkg holds:
  - opcode localparams/enum (OP_NOP..OP_HLT)
  - FSM state enum
  - flag bit positions
  - width helper function max3 used for OPR_W/IN_W
- Sub-module alu_param #(DATA_W): purely combinational.
  - Inputs: a, b, op.
  - Outputs: result, c, n, z.
- The core instantiates the FSM and both memories internally.

Test Plan:
- dmem[0]=5, dmem[1]=3; program LDA 0, ADD 1, OUT 2, HLT; pulse start -> out_valid pulses once, 9 clocks after start is sampled, with output_value=8 and out_index=2; then halted=1, busy=0, flags=000.
- dmem[0]=200, dmem[1]=100; LDA 0, ADD 1, JC 5, OUT 0, HLT, OUT 1, HLT -> acc=44, C=1, branch taken, single OUT with out_index=1 and value 44.
- dmem[0]=3, dmem[1]=5; LDA 0, SUB 1, OUT 0, HLT -> output 254, N=1, C=0, Z=0.
- Countdown: dmem[0]=3, dmem[1]=1; loop SUB/OUT/JZ exit/JMP loop -> out_valid pulses with values 2, 1, 0 in order, then HLT; also JMP at pc 31 to 0 wraps correctly.
- Assert load during busy to overwrite imem[pc+1] -> ignored, original program result unchanged; load and start in the same cycle -> new instruction 0 executes.
- Reset asserted in the DECODE cycle of an STA -> dmem unchanged, all outputs 0, state IDLE; restart with start reproduces the golden result.
